// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Command sequencer in front of the 24-bit combinational ALU (ALU24bit).
//   Accepts register-to-register commands over valid/ready, reads operands
//   from a 4 x DW register bank, drives the ALU for one cycle, captures the
//   result and flags, then writes back and retires.
//
//   Flow per legal command:   IDLE -> EXEC -> WB -> IDLE   (3 cycles)
//   Flow per illegal command: IDLE -> ERR  -> IDLE          (2 cycles)
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_op, cmd_dst/sa/sb       opcode (0..11 legal) and register indices
//   alu_a, alu_b, alu_sel       ALU operands/opcode (0/0/NOP outside EXEC)
//   alu_out, alu_z, alu_n       ALU result and flags
//   wr_en/wr_addr/wr_data       host register load, honoured in IDLE only
//   rd_addr / rd_data           combinational host read of the bank
//   done, err                   one-cycle retire pulses (err = illegal op)
//   flag_z, flag_n              sticky flags from last legal operation
//   op_count                    saturating count of legal retirements
//
// Optional feature (macro ALU_ISSUE_IMM_EN)
//   Adds cmd_imm_sel / cmd_imm; when cmd_imm_sel is set at accept, alu_b in
//   EXEC is the latched immediate instead of R[sb].
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DW   = 24,
    parameter int NREG = 4,
    parameter int CNTW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_dst,
    input  logic [$clog2(NREG)-1:0] cmd_sa,
    input  logic [$clog2(NREG)-1:0] cmd_sb,
`ifdef ALU_ISSUE_IMM_EN
    input  logic                    cmd_imm_sel,
    input  logic [DW-1:0]           cmd_imm,
`endif
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic [3:0]              alu_sel,
    input  logic [DW-1:0]           alu_out,
    input  logic                    alu_z,
    input  logic                    alu_n,
    input  logic                    wr_en,
    input  logic [$clog2(NREG)-1:0] wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic [$clog2(NREG)-1:0] rd_addr,
    output logic [DW-1:0]           rd_data,
    output logic                    done,
    output logic                    err,
    output logic                    flag_z,
    output logic                    flag_n,
    output logic [CNTW-1:0]         op_count
);
    localparam int AW = $clog2(NREG);
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LAST = 4'd11;

    typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

    state_t          state_q, state_d;
    logic            run_q;               // low until the first edge after reset release
    logic [3:0]      op_q, op_d;
    logic [AW-1:0]   dst_q, dst_d, sa_q, sa_d, sb_q, sb_d;
    logic [DW-1:0]   result_q, result_d;
    logic            z_q, z_d, n_q, n_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic            flag_z_q, flag_z_d, flag_n_q, flag_n_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d, err_q, err_d;
`ifdef ALU_ISSUE_IMM_EN
    logic            imm_sel_q, imm_sel_d;
    logic [DW-1:0]   imm_q, imm_d;
`endif

    assign cmd_ready = run_q && (state_q == IDLE);
    assign rd_data   = regs_q[rd_addr];
    assign done      = done_q;
    assign err       = err_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign op_count  = cnt_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        regs_d   = regs_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_sel  = OP_NOP;
`ifdef ALU_ISSUE_IMM_EN
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
`endif
        case (state_q)
            IDLE: begin
                // Host write lands on the accept edge; the command reads the
                // bank only in EXEC, so it sees the freshly written value.
                if (wr_en) begin
                    regs_d[wr_addr] = wr_data;
                end
                if (cmd_valid && cmd_ready) begin
                    op_d  = cmd_op;
                    dst_d = cmd_dst;
                    sa_d  = cmd_sa;
                    sb_d  = cmd_sb;
`ifdef ALU_ISSUE_IMM_EN
                    imm_sel_d = cmd_imm_sel;
                    imm_d     = cmd_imm;
`endif
                    state_d = (cmd_op <= OP_LAST) ? EXEC : ERR;
                end
            end
            EXEC: begin
                alu_a   = regs_q[sa_q];
`ifdef ALU_ISSUE_IMM_EN
                alu_b   = imm_sel_q ? imm_q : regs_q[sb_q];
`else
                alu_b   = regs_q[sb_q];
`endif
                alu_sel = op_q;
                result_d = alu_out;
                z_d      = alu_z;
                n_d      = alu_n;
                state_d  = WB;
            end
            WB: begin
                regs_d[dst_q] = result_q;
                flag_z_d      = z_q;
                flag_n_d      = n_q;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin // ERR: retire without touching bank, flags or count
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            op_q     <= '0;
            dst_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
`ifdef ALU_ISSUE_IMM_EN
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            op_q     <= op_d;
            dst_q    <= dst_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
`ifdef ALU_ISSUE_IMM_EN
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl. A stand-in ALU answers the DUT's ALU
//   port. A transaction-level model (bank contents, flags, count and a
//   "cycles until retire" countdown) predicts every output on each falling
//   edge; literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [1:0]    cmd_dst = '0, cmd_sa = '0, cmd_sb = '0;
    logic          cmd_imm_sel = 1'b0;
    logic [DW-1:0] cmd_imm = '0;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_sel;
    logic          alu_z, alu_n;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          done, err, flag_z, flag_n;
    logic [15:0]   op_count;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
`ifdef ALU_ISSUE_IMM_EN
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .done(done), .err(err), .flag_z(flag_z), .flag_n(flag_n),
        .op_count(op_count)
    );

    // Arithmetic of the 24-bit ALU, straight from the opcode table.
    function automatic logic [DW-1:0] alu_f(input logic [3:0] s,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (s)
            4'd0:    return a;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a << b;
            4'd4:    return a >> b;
            4'd5:    return a + 24'd1;
            4'd6:    return a - 24'd1;
            4'd7:    return -a;
            4'd8:    return ~a;
            4'd9:    return a & b;
            4'd10:   return a | b;
            4'd11:   return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_f(alu_sel, alu_a, alu_b);
    assign alu_z   = (alu_out == '0);
    assign alu_n   = alu_out[DW-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [DW-1:0] m_regs [4];
    logic          m_fz, m_fn, m_done, m_err, m_run, m_illegal;
    int            m_cnt, m_busy;
    logic [3:0]    m_op;
    logic [1:0]    m_dst, m_sa, m_sb;
    logic          m_immsel;
    logic [DW-1:0] m_imm, m_res;

    initial begin
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_fz = 0; m_fn = 0; m_done = 0; m_err = 0; m_run = 0; m_illegal = 0;
        m_cnt = 0; m_busy = 0; m_op = 0; m_dst = 0; m_sa = 0; m_sb = 0;
        m_immsel = 0; m_imm = 0; m_res = 0;
    end

    function automatic logic [DW-1:0] m_bval();
`ifdef ALU_ISSUE_IMM_EN
        return m_immsel ? m_imm : m_regs[m_sb];
`else
        return m_regs[m_sb];
`endif
    endfunction

    always @(negedge clk) begin
        logic          e_ready, exec, nd, ne;
        logic [DW-1:0] e_a, e_b;
        logic [3:0]    e_sel;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_fz = 0; m_fn = 0; m_cnt = 0; m_busy = 0;
            m_done = 0; m_err = 0; m_run = 0;
        end
        e_ready = m_run && (m_busy == 0);
        exec    = (m_busy == 2);
        e_sel   = exec ? m_op : 4'd0;
        e_a     = exec ? m_regs[m_sa] : '0;
        e_b     = exec ? m_bval() : '0;
        chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        chk("done",      32'(done),      32'(m_done));
        chk("err",       32'(err),       32'(m_err));
        chk("alu_sel",   32'(alu_sel),   32'(e_sel));
        chk("alu_a",     32'(alu_a),     32'(e_a));
        chk("alu_b",     32'(alu_b),     32'(e_b));
        chk("rd_data",   32'(rd_data),   32'(m_regs[rd_addr]));
        chk("flag_z",    32'(flag_z),    32'(m_fz));
        chk("flag_n",    32'(flag_n),    32'(m_fn));
        chk("op_count",  32'(op_count),  32'(m_cnt));
        if (rst_n) begin
            nd = 0; ne = 0;
            if (m_busy == 0) begin
                if (wr_en) m_regs[wr_addr] = wr_data;
                if (cmd_valid && e_ready) begin
                    m_op = cmd_op; m_dst = cmd_dst; m_sa = cmd_sa; m_sb = cmd_sb;
                    m_immsel = cmd_imm_sel; m_imm = cmd_imm;
                    m_illegal = (cmd_op > 4'd11);
                    m_busy = m_illegal ? 1 : 2;
                end
            end else if (m_busy == 2) begin
                m_res  = alu_f(m_op, m_regs[m_sa], m_bval());
                m_busy = 1;
            end else begin
                if (!m_illegal) begin
                    m_regs[m_dst] = m_res;
                    m_fz = (m_res == '0);
                    m_fn = m_res[DW-1];
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    ne = 1;
                end
                nd = 1;
                m_busy = 0;
            end
            m_done = nd; m_err = ne; m_run = 1;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [1:0] dst, sa, sb, output int acc);
        bit ok = 0;
        cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: op=%0d not accepted in 20 cycles", op);
            cmd_valid = 1'b0; acc = -100;
            return;
        end
        @(posedge clk); #1;
        acc = cyc; cmd_valid = 1'b0; wr_en = 1'b0;
        $display("cmd op=%0d dst=R%0d sa=R%0d sb=R%0d accepted at cycle %0d", op, dst, sa, sb, acc);
    endtask

    task automatic wait_done(input string name, input int acc, input int exp_lat, input logic exp_err);
        int lat = -1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin lat = cyc - acc; break; end
            @(posedge clk); #1;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        $display("host write R%0d = %06h", a, d);
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [DW-1:0] exp);
        rd_addr = a; #1;
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        // Reset and release
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // ADD R0 = R1 + R2
        host_wr(2'd1, 24'h000005);
        host_wr(2'd2, 24'h000003);
        issue(4'd1, 2'd0, 2'd1, 2'd2, a0);
        chk("add_sel_exec", 32'(alu_sel), 32'd1);
        wait_done("add", a0, 2, 1'b0);
        read_chk("add_r0", 2'd0, 24'h000008);
        chk("add_fz", 32'(flag_z), 32'd0);
        chk("add_fn", 32'(flag_n), 32'd0);
        chk("add_cnt", 32'(op_count), 32'd1);

        // SUB to zero, then NEG
        host_wr(2'd1, 24'h000007);
        host_wr(2'd2, 24'h000007);
        issue(4'd2, 2'd3, 2'd1, 2'd2, a0);
        wait_done("sub", a0, 2, 1'b0);
        read_chk("sub_r3", 2'd3, 24'h000000);
        chk("sub_fz", 32'(flag_z), 32'd1);
        chk("sub_fn", 32'(flag_n), 32'd0);
        issue(4'd7, 2'd3, 2'd1, 2'd0, a0);
        wait_done("neg", a0, 2, 1'b0);
        read_chk("neg_r3", 2'd3, 24'hFFFFF9);
        chk("neg_fz", 32'(flag_z), 32'd0);
        chk("neg_fn", 32'(flag_n), 32'd1);

        // Illegal opcode
        issue(4'd13, 2'd0, 2'd1, 2'd2, a0);
        chk("ill_sel", 32'(alu_sel), 32'd0);
        wait_done("ill", a0, 1, 1'b1);
        read_chk("ill_r0", 2'd0, 24'h000008);
        chk("ill_cnt", 32'(op_count), 32'd3);
        chk("ill_fn", 32'(flag_n), 32'd1);

        // Host write on the accept edge: command sees new value
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 24'h000009;
        issue(4'd1, 2'd0, 2'd2, 2'd2, a0);
        wait_done("wr_same_edge", a0, 2, 1'b0);
        read_chk("same_edge_r0", 2'd0, 24'h000012);

        // Back-to-back with valid held
        issue(4'd9,  2'd0, 2'd1, 2'd2, a0);
        issue(4'd10, 2'd1, 2'd1, 2'd2, a1);
        issue(4'd11, 2'd3, 2'd1, 2'd2, a2);
        chk("b2b_gap1", 32'(a1 - a0), 32'd3);
        chk("b2b_gap2", 32'(a2 - a1), 32'd3);
        wait_done("xor", a2, 2, 1'b0);
        read_chk("and_r0", 2'd0, 24'h000001);
        read_chk("or_r1",  2'd1, 24'h00000F);
        read_chk("xor_r3", 2'd3, 24'h000006);
        chk("b2b_cnt", 32'(op_count), 32'd7);

        // Host write during EXEC is ignored
        issue(4'd5, 2'd1, 2'd1, 2'd0, a0);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 24'hABCDEF;
        @(posedge clk); #1 wr_en = 1'b0;
        wait_done("inc", a0, 2, 1'b0);
        read_chk("inc_r1", 2'd1, 24'h000010);
        read_chk("blocked_wr_r2", 2'd2, 24'h000009);

        // Reset in the middle of EXEC of an ADD
        issue(4'd1, 2'd0, 2'd1, 2'd2, a0);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        read_chk("rst_r0", 2'd0, 24'h0);
        read_chk("rst_r1", 2'd1, 24'h0);
        read_chk("rst_r2", 2'd2, 24'h0);
        read_chk("rst_r3", 2'd3, 24'h0);
        chk("rst_cnt", 32'(op_count), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_n}), 32'd0);
        @(posedge clk); #2;
        chk("rst_ready", 32'(cmd_ready), 32'd1);

`ifdef ALU_ISSUE_IMM_EN
        host_wr(2'd1, 24'h000001);
        cmd_imm_sel = 1'b1; cmd_imm = 24'd23;
        issue(4'd3, 2'd0, 2'd1, 2'd0, a0);
        cmd_imm_sel = 1'b0;
        chk("imm_alu_b", 32'(alu_b), 32'h17);
        wait_done("mul_imm", a0, 2, 1'b0);
        read_chk("imm_r0", 2'd0, 24'h800000);
        chk("imm_fn", 32'(flag_n), 32'd1);
`endif

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
